cl_axil_bram_ctrl: RTL

//  AXI4-Lite slave that sequences single-word reads and writes into one port of the
//  256x32 dual-port BRAM (bram_2rw). It sits between the CL AXI-Lite interconnect and

---
 rtl/cl_axil_bram_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/cl_axil_bram_ctrl.sv
// AXI4-Lite slave sequencing single-word reads/writes into BRAM port A, round-robin arbitrated.
// Optional byte-strobe support (read-modify-write) when CL_AXIL_BRAM_CTRL_WSTRB_EN is defined.
module cl_axil_bram_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [31:0]             s_awaddr,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    input  logic [31:0]             s_araddr,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    bram_en,
    output logic                    bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_wdata,
    input  logic [DATA_WIDTH-1:0]   bram_rdata
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [3:0] {
        IDLE, WR_CAP, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP, RMW_RD, RMW_WAIT
    } state_t;

    state_t                  state;
    logic                    ready_en;
    logic                    rr_ptr;
    logic                    aw_got;
    logic                    w_got;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    in_idle_c;
    logic                    wr_req_c;
    logic                    rd_gnt_c;
    logic                    wr_gnt_c;
    logic                    aw_hs_c;
    logic                    w_hs_c;
    logic                    ar_hs_c;
    logic                    wr_go_c;
    logic [ADDR_WIDTH-1:0]   wr_addr_c;
    logic [DATA_WIDTH-1:0]   wr_data_c;
    logic                    unused_addr;

    assign s_bresp = 2'b00;
    assign s_rresp = 2'b00;

    // Readies are decoded from the current state and pending valids so a losing request never handshakes.
    assign in_idle_c = (state == IDLE) && ready_en;
    assign wr_req_c  = s_awvalid && s_wvalid;
    assign rd_gnt_c  = in_idle_c && s_arvalid && (!wr_req_c || rr_ptr);
    assign wr_gnt_c  = in_idle_c && wr_req_c && (!s_arvalid || !rr_ptr);
    assign s_awready = (in_idle_c && !rd_gnt_c) || ((state == WR_CAP) && !aw_got);
    assign s_wready  = (in_idle_c && !rd_gnt_c) || ((state == WR_CAP) && !w_got);
    assign s_arready = in_idle_c && !wr_gnt_c;

    assign aw_hs_c   = s_awvalid && s_awready;
    assign w_hs_c    = s_wvalid && s_wready;
    assign ar_hs_c   = s_arvalid && s_arready;
    assign wr_go_c   = (aw_got || aw_hs_c) && (w_got || w_hs_c);
    assign wr_addr_c = aw_got ? addr_q : s_awaddr[ADDR_WIDTH+1:2];
    assign wr_data_c = w_got ? wdata_q : s_wdata;

    assign unused_addr = ^{s_awaddr[31:ADDR_WIDTH+2], s_awaddr[1:0],
                           s_araddr[31:ADDR_WIDTH+2], s_araddr[1:0]};

`ifdef CL_AXIL_BRAM_CTRL_WSTRB_EN
    logic [STRB_W-1:0]       wstrb_q;
    logic [STRB_W-1:0]       wr_strb_c;
    logic [DATA_WIDTH-1:0]   merged_c;

    assign wr_strb_c = w_got ? wstrb_q : s_wstrb;

    // Strobed bytes from the captured write data, the rest from the word just read back.
    always_comb begin
        merged_c = bram_rdata;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (wstrb_q[i]) begin
                merged_c[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end
`else
    logic                    unused_strb;
    assign unused_strb = ^s_wstrb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready_en   <= 1'b0;
            rr_ptr     <= 1'b0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            s_bvalid   <= 1'b0;
            s_rvalid   <= 1'b0;
            s_rdata    <= '0;
`ifdef CL_AXIL_BRAM_CTRL_WSTRB_EN
            wstrb_q    <= '0;
`endif
        end else begin
            ready_en <= 1'b1;
            bram_en  <= 1'b0;
            bram_we  <= 1'b0;
            unique case (state)
                IDLE, WR_CAP: begin
                    if (ar_hs_c) begin
                        rr_ptr    <= ~rr_ptr;
                        bram_en   <= 1'b1;
                        bram_addr <= s_araddr[ADDR_WIDTH+1:2];
                        state     <= RD_EXEC;
                    end else if (wr_go_c) begin
                        rr_ptr    <= ~rr_ptr;
                        aw_got    <= 1'b0;
                        w_got     <= 1'b0;
                        addr_q    <= wr_addr_c;
                        wdata_q   <= wr_data_c;
                        bram_addr <= wr_addr_c;
`ifdef CL_AXIL_BRAM_CTRL_WSTRB_EN
                        wstrb_q   <= wr_strb_c;
                        if (wr_strb_c == '1) begin
                            bram_en    <= 1'b1;
                            bram_we    <= 1'b1;
                            bram_wdata <= wr_data_c;
                            state      <= WR_EXEC;
                        end else if (wr_strb_c == '0) begin
                            state      <= WR_EXEC;
                        end else begin
                            bram_en    <= 1'b1;
                            state      <= RMW_RD;
                        end
`else
                        bram_en    <= 1'b1;
                        bram_we    <= 1'b1;
                        bram_wdata <= wr_data_c;
                        state      <= WR_EXEC;
`endif
                    end else begin
                        // Half a write: hold whichever channel arrived first.
                        if (aw_hs_c) begin
                            aw_got <= 1'b1;
                            addr_q <= wr_addr_c;
                        end
                        if (w_hs_c) begin
                            w_got   <= 1'b1;
                            wdata_q <= wr_data_c;
`ifdef CL_AXIL_BRAM_CTRL_WSTRB_EN
                            wstrb_q <= wr_strb_c;
`endif
                        end
                        if (aw_hs_c || w_hs_c) begin
                            state <= WR_CAP;
                        end
                    end
                end
`ifdef CL_AXIL_BRAM_CTRL_WSTRB_EN
                RMW_RD: begin
                    state <= RMW_WAIT;
                end
                RMW_WAIT: begin
                    bram_en    <= 1'b1;
                    bram_we    <= 1'b1;
                    bram_wdata <= merged_c;
                    state      <= WR_EXEC;
                end
`endif
                WR_EXEC: begin
                    s_bvalid <= 1'b1;
                    state    <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RD_EXEC: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    s_rdata  <= bram_rdata;
                    s_rvalid <= 1'b1;
                    state    <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
